i2s_rx_unit: RTL and testbench
==============================

I2S_RX_UNIT -- requirements
Module: i2s_rx_unit

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port enable_in, input, 1: receiver enable; low forces IDLE.
REQ-004 SHALL have port clr_in, input, 1: clears err_out and frame_count_out.
REQ-005 SHALL have port sck_in, input, 1: I2S bit clock from the audioport sck_out; asynchronous to clk.
REQ-006 SHALL have port ws_in, input, 1: I2S word select from ws_out; low = left, high = right.
REQ-007 SHALL have port sdi_in, input, 1: I2S serial data from sdo_out, MSB first.
REQ-008 SHALL have port audio0_out, output, 24: last complete left sample.
REQ-009 SHALL have port audio1_out, output, 24: last complete right sample.
REQ-010 SHALL have port valid_out, output, 1: one-clk pulse when a new stereo pair is on audio0_out/audio1_out.
REQ-011 SHALL have port err_out, output, 1: sticky framing-error flag.
REQ-012 SHALL have port frame_count_out, output, 16: count of valid_out pulses, wraps 65535->0.

Function
REQ-013 SHALL pass sck_in, ws_in, sdi_in through 2-flop synchronizers plus one history flop; sck rise = sync'd sck 1 while history 0; rise detected 3 clk cycles after the pin edge.
REQ-014 SHALL sample sync'd ws and sdi in the cycle a sck rise is detected; clk SHALL be at least 4x the sck frequency.
REQ-015 SHALL define a WS-change rise as a sck rise whose sampled ws differs from ws sampled at the previous rise; sdi at that rise is not stored.
REQ-016 SHALL capture the MSB at the first sck rise after a WS-change rise, then 23 more bits on the following rises; bits beyond 24 before the next WS change are ignored.
REQ-017 SHALL implement FSM IDLE, LEFT, RIGHT: IDLE->LEFT on a 1->0 WS-change rise; LEFT->RIGHT on a 0->1 WS-change rise; RIGHT->LEFT on a 1->0 WS-change rise; any state->IDLE when enable_in=0.
REQ-018 SHALL hold a 5-bit bit counter, zeroed on every WS-change rise, incremented per captured bit, saturating at 24.
REQ-019 SHALL set err_out in the cycle after a WS-change rise in LEFT or RIGHT when the counter is <24; a word of that channel then remains unpublished.
REQ-020 SHALL, in the cycle after the 24th right-channel bit is captured, load both shift registers into audio0_out/audio1_out, pulse valid_out for one cycle, and increment frame_count_out, provided the preceding left word in the same frame had 24 bits.
REQ-021 SHALL keep audio0_out/audio1_out stable between valid_out pulses.
REQ-022 SHALL not publish a right word whose left word was short or missing (e.g. first RIGHT after leaving IDLE mid-frame).
REQ-023 SHALL give setting priority when clr_in and an error event coincide: err_out=1, frame_count_out=0.
REQ-024 SHALL abandon a partial frame without setting err_out when enable_in falls; re-enable waits in IDLE for the next 1->0 WS change.

Reset
REQ-025 SHALL on rst=1 at a clk edge set FSM=IDLE, counter=0, synchronizers=0, audio0_out=0, audio1_out=0, valid_out=0, err_out=0, frame_count_out=0.
REQ-026 SHALL abandon a frame in progress when reset is applied mid-frame; first valid_out after release requires a full left+right frame.

Structure
REQ-027 SHALL take I2S_WORD_BITS=24 and the FSM state typedef (IDLE, LEFT, RIGHT) from audioport_pkg.
REQ-028 SHALL place synchronizer and edge detection in sub-module i2s_rx_sync (outputs sck_rise, ws_s, sd_s).

Verification
REQ-029 SHALL cover: reset, enable=1, 2 frames left=0xABCDEF right=0x123456, sck=clk/8 -> valid_out pulses twice, audio0_out=0xABCDEF, audio1_out=0x123456, frame_count_out=2, err_out=0.
REQ-030 SHALL cover: 32 sck per channel with 8 padding bits of 1 -> samples unchanged by padding, err_out=0.
REQ-031 SHALL cover: left word truncated to 20 bits -> err_out=1 after next WS change, no valid_out for that frame; clr_in -> err_out=0, frame_count_out=0.
REQ-032 SHALL cover: enable_in dropped mid-right word then raised -> no valid_out until one full later frame; then values from that frame.
REQ-033 SHALL cover: rst pulsed mid-left word -> all outputs 0 next cycle; next full frame 0x800001/0x7FFFFF received correctly.
REQ-034 SHALL cover: 65536 frames -> frame_count_out wraps to 0 with valid_out still pulsing.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared audioport definitions for the I2S receiver: word width, counter widths,
// receiver state encoding and the stereo sample-pair payload.
package audioport_pkg;

   localparam int unsigned I2S_WORD_BITS    = 24;
   localparam int unsigned I2S_CNT_BITS     = 5;
   localparam int unsigned FRAME_COUNT_BITS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } i2s_rx_state_t;

   typedef struct packed {
      logic [I2S_WORD_BITS-1:0] left;
      logic [I2S_WORD_BITS-1:0] right;
   } i2s_sample_pair_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the asynchronous I2S pins into the clk domain and flags sck rising edges.
// ws_s/sd_s are aligned with sck_rise so they can be sampled in the same cycle.
module i2s_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic sck_in,
   input  logic ws_in,
   input  logic sdi_in,
   output logic sck_rise,
   output logic ws_s,
   output logic sd_s
);

   logic [1:0] sck_sync;
   logic [1:0] ws_sync;
   logic [1:0] sd_sync;
   logic       sck_hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync <= 2'b00;
         ws_sync  <= 2'b00;
         sd_sync  <= 2'b00;
         sck_hist <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[0], sck_in};
         ws_sync  <= {ws_sync[0], ws_in};
         sd_sync  <= {sd_sync[0], sdi_in};
         sck_hist <= sck_sync[1];
      end
   end

   assign sck_rise = sck_sync[1] & ~sck_hist;
   assign ws_s     = ws_sync[1];
   assign sd_s     = sd_sync[1];

endmodule

// File: rtl/i2s_rx_unit.sv
// I2S stereo receiver: deserialises 24-bit left/right words and publishes a pair
// once a complete left word is followed by a complete right word.
module i2s_rx_unit
   import audioport_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_in,
   input  logic        clr_in,
   input  logic        sck_in,
   input  logic        ws_in,
   input  logic        sdi_in,
   output logic [23:0] audio0_out,
   output logic [23:0] audio1_out,
   output logic        valid_out,
   output logic        err_out,
   output logic [15:0] frame_count_out
);

   localparam logic [I2S_CNT_BITS-1:0]     CNT_FULL = I2S_CNT_BITS'(I2S_WORD_BITS);
   localparam logic [I2S_CNT_BITS-1:0]     CNT_LAST = I2S_CNT_BITS'(I2S_WORD_BITS - 1);
   localparam logic [I2S_CNT_BITS-1:0]     CNT_ONE  = I2S_CNT_BITS'(1);
   localparam logic [FRAME_COUNT_BITS-1:0] FC_ONE   = FRAME_COUNT_BITS'(1);

   logic sck_rise;
   logic ws_s;
   logic sd_s;

   i2s_rx_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .sck_in   (sck_in),
      .ws_in    (ws_in),
      .sdi_in   (sdi_in),
      .sck_rise (sck_rise),
      .ws_s     (ws_s),
      .sd_s     (sd_s)
   );

   i2s_rx_state_t                 state_q, state_d;
   logic                          ws_prev_q, ws_prev_d;
   logic [I2S_CNT_BITS-1:0]       bit_cnt_q, bit_cnt_d;
   i2s_sample_pair_t              shift_q, shift_d;
   logic                          left_ok_q, left_ok_d;
   logic [I2S_WORD_BITS-1:0]      audio0_d, audio1_d;
   logic                          valid_d, err_d;
   logic [FRAME_COUNT_BITS-1:0]   frame_count_d;
   logic                          err_evt, publish;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         ws_prev_q       <= 1'b0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         left_ok_q       <= 1'b0;
         audio0_out      <= '0;
         audio1_out      <= '0;
         valid_out       <= 1'b0;
         err_out         <= 1'b0;
         frame_count_out <= '0;
      end else begin
         state_q         <= state_d;
         ws_prev_q       <= ws_prev_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         left_ok_q       <= left_ok_d;
         audio0_out      <= audio0_d;
         audio1_out      <= audio1_d;
         valid_out       <= valid_d;
         err_out         <= err_d;
         frame_count_out <= frame_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ws_prev_d     = ws_prev_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      left_ok_d     = left_ok_q;
      audio0_d      = audio0_out;
      audio1_d      = audio1_out;
      valid_d       = 1'b0;
      err_d         = err_out;
      frame_count_d = frame_count_out;
      err_evt       = 1'b0;
      publish       = 1'b0;

      // ws history tracks the line even while disabled so re-enable sees true WS edges
      if (sck_rise) begin
         ws_prev_d = ws_s;
      end

      if (!enable_in) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         left_ok_d = 1'b0;
      end else if (sck_rise) begin
         if (ws_s != ws_prev_q) begin
            bit_cnt_d = '0;
            err_evt   = (state_q != IDLE) && (bit_cnt_q < CNT_FULL);
            case (state_q)
               IDLE: begin
                  if (!ws_s) begin
                     state_d   = LEFT;
                     left_ok_d = 1'b0;
                  end
               end
               LEFT: begin
                  if (ws_s) begin
                     state_d   = RIGHT;
                     left_ok_d = (bit_cnt_q == CNT_FULL);
                  end
               end
               RIGHT: begin
                  if (!ws_s) begin
                     state_d   = LEFT;
                     left_ok_d = 1'b0;
                  end
               end
               default: begin
                  state_d   = IDLE;
                  left_ok_d = 1'b0;
               end
            endcase
         end else if ((state_q != IDLE) && (bit_cnt_q < CNT_FULL)) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            if (state_q == LEFT) begin
               shift_d.left = {shift_q.left[I2S_WORD_BITS-2:0], sd_s};
            end else begin
               shift_d.right = {shift_q.right[I2S_WORD_BITS-2:0], sd_s};
               publish       = (bit_cnt_q == CNT_LAST) && left_ok_q;
            end
         end
      end

      if (publish) begin
         audio0_d      = shift_q.left;
         audio1_d      = shift_d.right;
         valid_d       = 1'b1;
         frame_count_d = frame_count_out + FC_ONE;
      end

      if (clr_in) begin
         err_d         = 1'b0;
         frame_count_d = '0;
      end

      // a framing error wins over a simultaneous clear
      if (err_evt) begin
         err_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_i2s_rx_unit.sv
// Self-checking bench for i2s_rx_unit: drives I2S frames at sck = clk/8 and
// compares published stereo pairs against a scoreboard of sent frames.
module tb_i2s_rx_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_in;
   logic        clr_in;
   logic        sck_in;
   logic        ws_in;
   logic        sdi_in;
   logic [23:0] audio0_out;
   logic [23:0] audio1_out;
   logic        valid_out;
   logic        err_out;
   logic [15:0] frame_count_out;

   i2s_rx_unit dut (
      .clk             (clk),
      .rst             (rst),
      .enable_in       (enable_in),
      .clr_in          (clr_in),
      .sck_in          (sck_in),
      .ws_in           (ws_in),
      .sdi_in          (sdi_in),
      .audio0_out      (audio0_out),
      .audio1_out      (audio1_out),
      .valid_out       (valid_out),
      .err_out         (err_out),
      .frame_count_out (frame_count_out)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_valid = 0;
   logic [47:0] exp_q[$];
   logic [47:0] exp_pair;
   logic [15:0] exp_fc = 16'd0;
   logic [23:0] last_l = 24'd0;
   logic [23:0] last_r = 24'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard consumer: every valid_out pulse must match the oldest sent frame
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_pair = exp_q.pop_front();
            exp_fc   = exp_fc + 16'd1;
            last_l   = exp_pair[47:24];
            last_r   = exp_pair[23:0];
            check("audio0", 32'(audio0_out), 32'(last_l));
            check("audio1", 32'(audio1_out), 32'(last_r));
            check("frame_count", 32'(frame_count_out), 32'(exp_fc));
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sck_bit(input logic ws, input logic sd);
      sck_in = 1'b0;
      ws_in  = ws;
      sdi_in = sd;
      clks(4);
      sck_in = 1'b1;
      clks(4);
   endtask

   // slot position 0 is the WS-change rise; positions 1..nbits carry the word MSB first
   task automatic send_slot(input logic ws, input logic [23:0] w, input int nbits,
                            input int slot, input logic pad);
      for (int i = 0; i < slot; i++) begin
         logic b;
         b = pad;
         if (i >= 1 && i <= nbits) b = w[24 - i];
         sck_bit(ws, b);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot,
                             input logic pad);
      send_slot(1'b0, l, 24, slot, pad);
      exp_q.push_back({l, r});
      send_slot(1'b1, r, 24, slot, pad);
   endtask

   task automatic check_idle(input string tag, input logic exp_err);
      clks(16);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_err"}, 32'(err_out), 32'(exp_err));
      check({tag, "_fc"}, 32'(frame_count_out), 32'(exp_fc));
      check({tag, "_audio0_hold"}, 32'(audio0_out), 32'(last_l));
      check({tag, "_audio1_hold"}, 32'(audio1_out), 32'(last_r));
   endtask

   initial begin
      int vcnt;
      rst       = 1'b1;
      enable_in = 1'b0;
      clr_in    = 1'b0;
      sck_in    = 1'b0;
      ws_in     = 1'b1;
      sdi_in    = 1'b0;
      clks(4);
      check("rst_audio0", 32'(audio0_out), 32'd0);
      check("rst_audio1", 32'(audio1_out), 32'd0);
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_err", 32'(err_out), 32'd0);
      check("rst_fc", 32'(frame_count_out), 32'd0);
      rst       = 1'b0;
      enable_in = 1'b1;
      clks(2);

      // basic frames, no padding
      sck_bit(1'b1, 1'b0);
      sck_bit(1'b1, 1'b0);
      send_frame(24'hABCDEF, 24'h123456, 25, 1'b0);
      send_frame(24'hABCDEF, 24'h123456, 25, 1'b0);
      check_idle("basic", 1'b0);
      check("basic_valid_count", 32'(n_valid), 32'd2);

      // 32-sck slots with trailing ones must not disturb the words
      send_frame(24'h5A5A5A, 24'hC3C3C3, 32, 1'b1);
      send_frame(24'h000001, 24'hFFFFFE, 32, 1'b1);
      check_idle("padded", 1'b0);

      // left word cut to 20 bits: error, right word withheld
      vcnt = n_valid;
      send_slot(1'b0, 24'h111111, 20, 21, 1'b0);
      send_slot(1'b1, 24'h222222, 24, 25, 1'b0);
      check_idle("short_left", 1'b1);
      check("short_left_no_valid", 32'(n_valid), 32'(vcnt));
      clr_in = 1'b1;
      clks(1);
      clr_in = 1'b0;
      exp_fc = 16'd0;
      check("clr_err", 32'(err_out), 32'd0);
      check("clr_fc", 32'(frame_count_out), 32'd0);
      send_frame(24'h0A0B0C, 24'hD0E0F0, 25, 1'b0);
      check_idle("after_clr", 1'b0);

      // enable dropped mid right word
      vcnt = n_valid;
      send_slot(1'b0, 24'h0F0F0F, 24, 25, 1'b0);
      send_slot(1'b1, 24'hF0F0F0, 24, 10, 1'b0);
      enable_in = 1'b0;
      clks(8);
      enable_in = 1'b1;
      send_slot(1'b1, 24'hF0F0F0, 0, 15, 1'b1);
      check("enable_drop_no_valid", 32'(n_valid), 32'(vcnt));
      send_frame(24'h13579B, 24'h2468AC, 25, 1'b0);
      check_idle("reenable", 1'b0);

      // reset pulsed mid left word
      send_slot(1'b0, 24'h777777, 24, 11, 1'b0);
      rst = 1'b1;
      clks(1);
      check("midrst_audio0", 32'(audio0_out), 32'd0);
      check("midrst_audio1", 32'(audio1_out), 32'd0);
      check("midrst_valid", 32'(valid_out), 32'd0);
      check("midrst_err", 32'(err_out), 32'd0);
      check("midrst_fc", 32'(frame_count_out), 32'd0);
      rst    = 1'b0;
      exp_fc = 16'd0;
      last_l = 24'd0;
      last_r = 24'd0;
      vcnt   = n_valid;
      send_slot(1'b0, 24'h777777, 0, 14, 1'b0);
      send_slot(1'b1, 24'h888888, 24, 25, 1'b0);
      check("midrst_no_valid", 32'(n_valid), 32'(vcnt));
      send_frame(24'h800001, 24'h7FFFFF, 25, 1'b0);
      check_idle("post_rst", 1'b0);

      // frame counter wrap, counter preloaded close to the top
      force dut.frame_count_out = 16'hFFFE;
      #2;
      release dut.frame_count_out;
      exp_fc = 16'hFFFE;
      clks(1);
      check("wrap_preload", 32'(frame_count_out), 32'h0000FFFE);
      vcnt = n_valid;
      send_frame(24'hFEDCBA, 24'h012345, 25, 1'b0);
      send_frame(24'h00FF00, 24'hFF00FF, 25, 1'b0);
      check_idle("wrap", 1'b0);
      check("wrap_fc_zero", 32'(frame_count_out), 32'd0);
      check("wrap_valid_count", 32'(n_valid - vcnt), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
